// File: rtl/arm_mc_pkg.sv
// Shared types and mux-select encodings for the multicycle ARM main sequencer.
package arm_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_FAULT
  } state_t;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_ALUOUT = 1'b1;

  localparam logic [1:0] SRCB_WD    = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;

  localparam logic [1:0] OP_DP      = 2'b00;
  localparam logic [1:0] OP_MEM     = 2'b01;
  localparam logic [1:0] OP_BR      = 2'b10;

endpackage

// File: rtl/arm_mc_main_fsm_if.sv
// Control bundle between the main sequencer (master) and the datapath/memory (slave).
interface arm_mc_main_fsm_if;
  logic [1:0] op;
  logic [5:0] funct;
  logic       mem_ready;
  logic       mem_req;
  logic       ir_write;
  logic       next_pc;
  logic       adr_src;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic       alu_op;
  logic       reg_w;
  logic       mem_w;
  logic       branch;
  logic       instr_done;
  logic       fault;

  modport master (
    input  op, funct, mem_ready,
    output mem_req, ir_write, next_pc, adr_src, alu_src_a, alu_src_b, result_src,
           alu_op, reg_w, mem_w, branch, instr_done, fault
  );

  modport slave (
    output op, funct, mem_ready,
    input  mem_req, ir_write, next_pc, adr_src, alu_src_a, alu_src_b, result_src,
           alu_op, reg_w, mem_w, branch, instr_done, fault
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on memory; flags timeout when the count reaches the limit.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TMO_W       = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic tmo
);
  localparam logic [TMO_W-1:0] LIMIT = TMO_W'(MEM_TIMEOUT);

  logic [TMO_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr)
      cnt_d = '0;
    else if (inc && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // A zero limit disables the timeout entirely.
  assign tmo = (MEM_TIMEOUT != 0) && (cnt_q == LIMIT);
endmodule

// File: rtl/arm_mc_main_fsm.sv
// Main sequencing FSM of the multicycle ARMv4-subset core: walks each instruction through
// fetch/decode/execute/memory/writeback and drives datapath selects and raw enables.
module arm_mc_main_fsm
  import arm_mc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TMO_W       = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  arm_mc_main_fsm_if.master    bus
);
  state_t state_q, state_d;
  logic   hold_q, hold_d;
  logic   tmo, clr, inc;

  logic       mem_req_s, ir_write_s, next_pc_s, adr_src_s, alu_src_a_s, alu_op_s;
  logic       reg_w_s, mem_w_s, branch_s, instr_done_s, fault_s;
  logic [1:0] alu_src_b_s, result_src_s;

  // hold_q keeps everything idle for one edge after reset falls (synchronous release).
  always_comb hold_d = 1'b0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_FETCH;
      hold_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
                else if (tmo)      state_d = S_FAULT;
      S_DECODE: case (bus.op)
                  OP_MEM:  state_d = S_MEMADR;
                  OP_DP:   state_d = bus.funct[5] ? S_EXECI : S_EXECR;
                  OP_BR:   state_d = S_BRANCH;
                  default: state_d = S_FAULT;
                endcase
      S_MEMADR: state_d = bus.funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
                else if (tmo)      state_d = S_FAULT;
      S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH;
                else if (tmo)      state_d = S_FAULT;
      S_MEMWB, S_ALUWB, S_BRANCH: state_d = S_FETCH;
      S_EXECR, S_EXECI:           state_d = S_ALUWB;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_FAULT;
    endcase
    if (hold_q) state_d = state_q;
  end

  always_comb begin
    mem_req_s    = 1'b0;  ir_write_s  = 1'b0;     next_pc_s    = 1'b0;
    adr_src_s    = ADR_PC; alu_src_a_s = 1'b0;    alu_src_b_s  = SRCB_WD;
    result_src_s = RES_ALUOUT; alu_op_s = 1'b0;   reg_w_s      = 1'b0;
    mem_w_s      = 1'b0;  branch_s    = 1'b0;     instr_done_s = 1'b0;
    fault_s      = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_s   = 1'b1;  alu_src_a_s  = 1'b1; alu_src_b_s = SRCB_FOUR;
        result_src_s = RES_ALURES;
        ir_write_s  = bus.mem_ready; next_pc_s = bus.mem_ready;
      end
      S_DECODE: begin
        alu_src_a_s = 1'b1; alu_src_b_s = SRCB_FOUR; result_src_s = RES_ALURES;
      end
      S_MEMADR: alu_src_b_s = SRCB_IMM;
      S_MEMRD:  begin mem_req_s = 1'b1; adr_src_s = ADR_ALUOUT; end
      S_MEMWB:  begin result_src_s = RES_DATA; reg_w_s = 1'b1; instr_done_s = 1'b1; end
      S_MEMWR: begin
        mem_req_s = 1'b1; mem_w_s = 1'b1; adr_src_s = ADR_ALUOUT;
        instr_done_s = bus.mem_ready;
      end
      S_EXECR:  alu_op_s = 1'b1;
      S_EXECI:  begin alu_op_s = 1'b1; alu_src_b_s = SRCB_IMM; end
      S_ALUWB:  begin reg_w_s = 1'b1; instr_done_s = 1'b1; end
      S_BRANCH: begin
        alu_src_b_s = SRCB_IMM; result_src_s = RES_ALURES;
        branch_s = 1'b1; instr_done_s = 1'b1;
      end
      S_FAULT:  fault_s = 1'b1;
      default:  fault_s = 1'b1;
    endcase
  end

  assign bus.mem_req    = mem_req_s    & ~hold_q;
  assign bus.ir_write   = ir_write_s   & ~hold_q;
  assign bus.next_pc    = next_pc_s    & ~hold_q;
  assign bus.reg_w      = reg_w_s      & ~hold_q;
  assign bus.mem_w      = mem_w_s      & ~hold_q;
  assign bus.branch     = branch_s     & ~hold_q;
  assign bus.instr_done = instr_done_s & ~hold_q;
  assign bus.fault      = fault_s      & ~hold_q;
  assign bus.adr_src    = adr_src_s;
  assign bus.alu_src_a  = alu_src_a_s;
  assign bus.alu_src_b  = alu_src_b_s;
  assign bus.result_src = result_src_s;
  assign bus.alu_op     = alu_op_s;

  assign inc = bus.mem_req & ~bus.mem_ready;
  assign clr = (state_d != state_q);

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT), .TMO_W(TMO_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (clr),
    .inc   (inc),
    .tmo   (tmo)
  );
endmodule
